// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port
// among NUM_REQ burst requesters (valid/ready per requester).
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 2,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    output logic [TAG_W-1:0]         fifo_tag_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic [15:0]              beat_cnt_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [4:0] CAP = 5'(BURST_MAX - 1);

    state_e             state_q;
    logic [TAG_W-1:0]   win_q;
    logic [TAG_W-1:0]   last_q;
    logic [4:0]         burst_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [15:0]        beat_q;
    logic [15:0]        beat_d;

    logic               any_valid;
    logic [TAG_W-1:0]   pick;
    logic [TAG_W-1:0]   idx;
    logic               accept;
    logic               release_c;

    // Rotating priority search: lowest offset from last_q+1 wins.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = TAG_W'((int'(last_q) + i) % NUM_REQ);
            if (req_valid_i[idx]) begin
                any_valid = 1'b1;
                pick      = idx;
            end
        end
    end

    // Data path: only the granted requester sees ready.
    always_comb begin
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;
        fifo_tag_o   = '0;
        if (state_q == GRANT) begin
            req_ready_o[win_q] = !fifo_full_i;
            fifo_wr_en_o = req_valid_i[win_q] & !fifo_full_i;
            fifo_wdata_o = req_data_i[int'(win_q)*WIDTH +: WIDTH];
            fifo_tag_o   = win_q;
        end
    end

    assign accept    = fifo_wr_en_o;
    assign release_c = accept
                     & (req_last_i[win_q] | (burst_q == CAP));
    assign beat_d    = beat_q + 16'(accept);

    // Grant FSM: arbitrate in IDLE, hold grant until release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            win_q   <= '0;
            last_q  <= TAG_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        state_q <= GRANT;
                        win_q   <= pick;
                        grant_q <= ONE << pick;
                        burst_q <= '0;
                    end
                end
                GRANT: begin
                    if (release_c) begin
                        state_q <= IDLE;
                        last_q  <= win_q;
                        grant_q <= '0;
                    end else if (accept) begin
                        burst_q <= burst_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Running total of FIFO writes, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = (state_q == GRANT);
    assign beat_cnt_o = beat_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one sync FIFO write port among NUM_REQ requesters. Each requester pushes bursts with a valid/ready handshake. The arbiter grants one requester at a time and holds the grant until the burst ends or BURST_MAX beats are written. It forwards the granted data and its source tag to the FIFO write side, and never writes while the FIFO reports full.

Parameters:
WIDTH, 8, data width of each requester and of the FIFO write data
NUM_REQ, 4, number of requesters (2..8)
TAG_W, 2, source tag width; must equal clog2(NUM_REQ)
BURST_MAX, 4, maximum beats per grant (1..16)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
req_valid_i  input  NUM_REQ  per-requester beat valid
req_data_i  input  NUM_REQ*WIDTH  packed data; requester k uses bits [k*WIDTH +: WIDTH]
req_last_i  input  NUM_REQ  last beat of the requester's burst
req_ready_o  output  NUM_REQ  per-requester beat accepted this cycle if valid
fifo_full_i  input  1  FIFO full flag
fifo_wr_en_o  output  1  FIFO write enable
fifo_wdata_o  output  WIDTH  FIFO write data
fifo_tag_o  output  TAG_W  index of the requester that owns the current write
grant_o  output  NUM_REQ  one-hot current grant; all zero when idle
busy_o  output  1  high while in GRANT state
beat_cnt_o  output  16  total beats written to the FIFO, wraps at 65535->0

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, grant_o=0, last_grant=NUM_REQ-1, burst counter=0, beat_cnt_o=0. Combinationally, req_ready_o=0, fifo_wr_en_o=0 and busy_o=0.
- Two-state FSM: IDLE, GRANT.
- IDLE: if any req_valid_i bit is set, pick the first set bit searching from last_grant+1 upward, modulo NUM_REQ.
  - Next edge: grant_o=one-hot(winner), burst counter=0, state=GRANT.
  - No valids: stay in IDLE.
  - No data moves in IDLE.
- GRANT, winner w:
  - req_ready_o[w] = !fifo_full_i. All other ready bits are 0.
  - Accept = req_valid_i[w] & req_ready_o[w].
  - fifo_wr_en_o = accept. Combinational, zero latency; never high while fifo_full_i=1.
  - fifo_wdata_o = req_data_i slice w. fifo_tag_o = w. When idle, both are driven 0.
  - Each accept increments the burst counter and beat_cnt_o.
- Release condition: an accept with req_last_i[w]=1, or an accept that is beat number BURST_MAX of the grant.
  - Next edge: state=IDLE, last_grant=w, grant_o=0.
- Release always costs one IDLE arbitration cycle. Peak throughput is BURST_MAX beats per BURST_MAX+1 cycles.
- Stall cases:
  - fifo_full_i=1 in GRANT: ready is low and the grant is held. The burst counter does not advance.
  - Granted requester drops valid mid-burst: the grant is held with no timeout. Requesters must complete their bursts.
- Requests from non-granted requesters are ignored until the next IDLE. Their valids may stay asserted.
- Fairness: after w releases, w has the lowest priority in the next arbitration. With all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Simultaneous accept-with-last and fifo_full_i rising on the same edge: the beat is written (full is sampled combinationally in that cycle). The release proceeds normally.
- Reset mid-burst: the burst is abandoned and all outputs drop immediately. The next arbitration starts from requester 0.
- grant_o is always one-hot or zero.

Test Plan:
- Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd), FIFO not full -> grant_o=0100 one cycle after valid. 3 consecutive fifo_wr_en_o pulses with tag=2 and data in order. Back to IDLE. beat_cnt_o=3.
- Round-robin: all 4 requesters continuously valid, 1-beat bursts with last=1 -> grant order 0,1,2,3,0,1. Each grant lasts 1 cycle, followed by 1 IDLE cycle.
- Burst cap: req 1 valid with last never asserted, BURST_MAX=4 -> exactly 4 writes. Release to IDLE. Req 1 regranted only if no other requester is valid.
- Full backpressure: req 0 granted, fifo_full_i=1 for 5 cycles mid-burst -> req_ready_o=0 and fifo_wr_en_o=0 for those 5 cycles. Grant held. Remaining beats resume in order once full clears.
- Async reset mid-burst: rst_i low after 2 of 4 beats -> grant_o, busy_o and fifo_wr_en_o go 0 immediately and beat_cnt_o=0. After release, the first arbitration with all requesters valid grants req 0.
- Counter wrap: preload by running 65535 single-beat writes, then 1 more -> beat_cnt_o reads 65535, then 0.
